// File: rtl/load_store_control_if.sv
// Load/store controller bus bundle: run/IR/memory_done into the controller,
// datapath strobes, ALU opcode and status out. master = controller side.
interface load_store_control_if #(
  parameter int OPC_W = 5
);
  logic             run;
  logic [31:0]      IR;
  logic             memory_done;
  logic             PCout;
  logic             IncPC;
  logic             PCin;
  logic             MARin;
  logic             MDRin;
  logic             MDRout;
  logic             IRin;
  logic             Mem_Read;
  logic             Mem_Write;
  logic             Mem_enable512x32;
  logic             Gra;
  logic             Grb;
  logic             Rin;
  logic             Rout;
  logic             BAout;
  logic             Yin;
  logic             Zin;
  logic             Zlo_out;
  logic             Cout;
  logic [OPC_W-1:0] opcode;
  logic             instr_done;
  logic             halted;

  modport master (
    input  run, IR, memory_done,
    output PCout, IncPC, PCin,
    output MARin, MDRin, MDRout, IRin,
    output Mem_Read, Mem_Write, Mem_enable512x32,
    output Gra, Grb, Rin, Rout, BAout,
    output Yin, Zin, Zlo_out, Cout,
    output opcode, instr_done, halted
  );

  modport slave (
    output run, IR, memory_done,
    input  PCout, IncPC, PCin,
    input  MARin, MDRin, MDRout, IRin,
    input  Mem_Read, Mem_Write, Mem_enable512x32,
    input  Gra, Grb, Rin, Rout, BAout,
    input  Yin, Zin, Zlo_out, Cout,
    input  opcode, instr_done, halted
  );
endinterface

// File: rtl/load_store_control.sv
// Load/store sequencer (ld/ldi/st) stepping IDLE,T0..T7,HALT.
// Ports: Clock, clear (async active-high), bus (master modport).
// Option LSC_MEM_WAIT_EN: memory steps hold until memory_done.
module load_store_control #(
  parameter int OPC_W = 5
) (
  input  logic Clock,
  input  logic clear,
  load_store_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    K_LD, K_LDI, K_ST
  } kind_t;

  typedef struct packed {
    logic             pc_out;
    logic             inc_pc;
    logic             pc_in;
    logic             mar_in;
    logic             mdr_in;
    logic             mdr_out;
    logic             ir_in;
    logic             mem_rd;
    logic             mem_wr;
    logic             mem_en;
    logic             gra;
    logic             grb;
    logic             r_in;
    logic             r_out;
    logic             ba_out;
    logic             y_in;
    logic             z_in;
    logic             zlo_out;
    logic             c_out;
    logic [OPC_W-1:0] opcode;
    logic             done;
    logic             halted;
  } ctl_t;

  localparam logic [OPC_W-1:0] OPC_ADD = OPC_W'(5'b00011);

  state_t state_q, state_d;
  kind_t  kind_q, kind_d;
  ctl_t   ctl_q, ctl_d;
  logic   mem_ok;
  logic   unused_in;

`ifdef LSC_MEM_WAIT_EN
  assign mem_ok = bus.memory_done;
`else
  assign mem_ok = 1'b1;
`endif

  assign unused_in = ^{bus.IR[26:0], bus.memory_done};

  // Outputs are registered from the next-state decode so each
  // step's strobes line up with state_q for one full cycle.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      kind_q  <= K_LD;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    unique case (state_q)
      S_IDLE: if (bus.run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ok) state_d = S_T2;
      S_T2: begin
        state_d = S_T3;
        case (bus.IR[31:27])
          5'b00000: kind_d = K_LD;
          5'b00001: kind_d = K_LDI;
          5'b00010: kind_d = K_ST;
          default:  state_d = S_HALT;
        endcase
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        if (kind_q == K_LDI)
          state_d = bus.run ? S_T0 : S_IDLE;
        else
          state_d = S_T6;
      end
      // only the ld read waits in T6; st just stages MDR
      S_T6: if (kind_q == K_ST || mem_ok) state_d = S_T7;
      S_T7: begin
        if (kind_q == K_LD || mem_ok)
          state_d = bus.run ? S_T0 : S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl_d = '0;
    unique case (state_d)
      S_T0: begin
        ctl_d.pc_out = 1'b1;
        ctl_d.mar_in = 1'b1;
        ctl_d.inc_pc = 1'b1;
        ctl_d.z_in   = 1'b1;
      end
      S_T1: begin
        ctl_d.zlo_out = 1'b1;
        ctl_d.pc_in   = 1'b1;
        ctl_d.mem_rd  = 1'b1;
        ctl_d.mem_en  = 1'b1;
        ctl_d.mdr_in  = 1'b1;
      end
      S_T2: begin
        ctl_d.mdr_out = 1'b1;
        ctl_d.ir_in   = 1'b1;
      end
      S_T3: begin
        ctl_d.grb    = 1'b1;
        ctl_d.ba_out = 1'b1;
        ctl_d.y_in   = 1'b1;
      end
      S_T4: begin
        ctl_d.c_out  = 1'b1;
        ctl_d.z_in   = 1'b1;
        ctl_d.opcode = OPC_ADD;
      end
      S_T5: begin
        ctl_d.zlo_out = 1'b1;
        if (kind_d == K_LDI) begin
          ctl_d.gra  = 1'b1;
          ctl_d.r_in = 1'b1;
          ctl_d.done = 1'b1;
        end else begin
          ctl_d.mar_in = 1'b1;
        end
      end
      S_T6: begin
        ctl_d.mdr_in = 1'b1;
        if (kind_d == K_ST) begin
          ctl_d.gra   = 1'b1;
          ctl_d.r_out = 1'b1;
        end else begin
          ctl_d.mem_rd = 1'b1;
          ctl_d.mem_en = 1'b1;
        end
      end
      S_T7: begin
        ctl_d.done = 1'b1;
        if (kind_d == K_ST) begin
          ctl_d.mem_wr = 1'b1;
          ctl_d.mem_en = 1'b1;
        end else begin
          ctl_d.mdr_out = 1'b1;
          ctl_d.gra     = 1'b1;
          ctl_d.r_in    = 1'b1;
        end
      end
      S_HALT: ctl_d.halted = 1'b1;
      default: ctl_d = '0;
    endcase
  end

  assign bus.PCout            = ctl_q.pc_out;
  assign bus.IncPC            = ctl_q.inc_pc;
  assign bus.PCin             = ctl_q.pc_in;
  assign bus.MARin            = ctl_q.mar_in;
  assign bus.MDRin            = ctl_q.mdr_in;
  assign bus.MDRout           = ctl_q.mdr_out;
  assign bus.IRin             = ctl_q.ir_in;
  assign bus.Mem_Read         = ctl_q.mem_rd;
  assign bus.Mem_Write        = ctl_q.mem_wr;
  assign bus.Mem_enable512x32 = ctl_q.mem_en;
  assign bus.Gra              = ctl_q.gra;
  assign bus.Grb              = ctl_q.grb;
  assign bus.Rin              = ctl_q.r_in;
  assign bus.Rout             = ctl_q.r_out;
  assign bus.BAout            = ctl_q.ba_out;
  assign bus.Yin              = ctl_q.y_in;
  assign bus.Zin              = ctl_q.z_in;
  assign bus.Zlo_out          = ctl_q.zlo_out;
  assign bus.Cout             = ctl_q.c_out;
  assign bus.opcode           = ctl_q.opcode;
  assign bus.instr_done       = ctl_q.done;
  assign bus.halted           = ctl_q.halted;

endmodule
